// File: rtl/switch_pkg.sv
// Shared definitions for the switch output-port scheduler.
//   NUM_QUEUES          number of input queues feeding one output port
//   GRANT_Q1            one-hot grant selecting queue 1 (reset / recovery value)
//   state_t             scheduler state encoding
//   DEFAULT_DATA_WIDTH  default byte width of queue and output data
//   DEFAULT_COUNT_WIDTH default width of the payload down-counter
package switch_pkg;

    localparam int NUM_QUEUES          = 4;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_COUNT_WIDTH = 8;

    // Grant vectors are indexed [1:NUM_QUEUES], so queue 1 is the MSB.
    localparam logic [1:NUM_QUEUES] GRANT_Q1 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

endpackage

// File: rtl/output_port_scheduler_if.sv
// Byte-stream bundle between the four input queues, the scheduler and the
// output port.
//   queue_empty  per-queue empty flag (first-word-fall-through queues)
//   queue_data   head word of each queue, queue k in slice k-1
//   queue_rd     one-hot pop strobe towards the queues
//   out_valid / out_ready / out_data / out_sop / out_eop  output byte stream
// master: the scheduler; slave: the queue/port side.
interface output_port_scheduler_if
    import switch_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [1:NUM_QUEUES]              queue_empty;
    logic [NUM_QUEUES*DATA_WIDTH-1:0] queue_data;
    logic [1:NUM_QUEUES]              queue_rd;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_sop;
    logic                             out_eop;

    modport master (
        input  queue_empty,
        input  queue_data,
        output queue_rd,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sop,
        output out_eop
    );

    modport slave (
        output queue_empty,
        output queue_data,
        input  queue_rd,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sop,
        input  out_eop
    );
endinterface

// File: rtl/output_port_scheduler_grant_rotator.sv
// Round-robin grant rotator (combinational).
//   grant       current one-hot grant, [1] = queue 1
//   advance     rotate one step when high, otherwise pass the grant through
//   grant_next  resulting grant; order 1->2->3->4->1, an invalid
//               (zero or multi-hot) grant rotates to queue 1
module grant_rotator
    import switch_pkg::*;
(
    input  logic [1:NUM_QUEUES] grant,
    input  logic                advance,
    output logic [1:NUM_QUEUES] grant_next
);

    logic [1:NUM_QUEUES] rotated;

    // Each queue takes the grant from its predecessor; queue 1 wraps from the last.
    for (genvar gi = 1; gi <= NUM_QUEUES; gi++) begin : g_rotate
        localparam int SRC = (gi == 1) ? NUM_QUEUES : gi - 1;
        assign rotated[gi] = grant[SRC];
    end

    always_comb begin
        grant_next = grant;
        if (advance) begin
            grant_next = $onehot(grant) ? rotated : GRANT_Q1;
        end
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Per-output-port packet scheduler. Grants one input queue at a time and
// forwards one whole packet (header byte + payload) from it, then rotates the
// grant round-robin. Header bits [COUNT_WIDTH-1:0] hold the payload length.
//   clk              system clock, rising edge
//   reset            synchronous active-high reset
//   bus              queue side + ready/valid output byte stream (master)
//   read_from_queue  registered one-hot grant, [1] = queue 1
//   down_counter     payload bytes still to send
// COUNT_WIDTH must not exceed DATA_WIDTH.
module output_port_scheduler
    import switch_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    output_port_scheduler_if.master  bus,
    output logic [1:NUM_QUEUES]      read_from_queue,
    output logic [COUNT_WIDTH-1:0]   down_counter
);

    state_t                 state_reg, state_next;
    logic [1:NUM_QUEUES]    grant_reg, grant_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic                   advance;

    logic [DATA_WIDTH-1:0]  masked_data [1:NUM_QUEUES];
    logic [DATA_WIDTH-1:0]  data_mux;
    logic [COUNT_WIDTH-1:0] hdr_len;
    logic                   grant_has_data;
    logic                   valid_c;
    logic                   xfer;

    // One-hot AND-OR mux of the queue head words.
    for (genvar gi = 1; gi <= NUM_QUEUES; gi++) begin : g_data_mux
        assign masked_data[gi] = bus.queue_data[(gi-1)*DATA_WIDTH +: DATA_WIDTH]
                               & {DATA_WIDTH{grant_reg[gi]}};
    end

    always_comb begin
        data_mux = '0;
        for (int i = 1; i <= NUM_QUEUES; i++) begin
            data_mux = data_mux | masked_data[i];
        end
    end

    assign hdr_len = data_mux[COUNT_WIDTH-1:0];

    // A corrupted grant never reports data, so IDLE rotates it back to queue 1
    // and no multi-hot pop can be issued.
    assign grant_has_data = $onehot(grant_reg) && |(grant_reg & ~bus.queue_empty);

    // Valid depends only on state and queue flags (never on out_ready). Reset
    // masks it so a packet abandoned by reset pops nothing on the reset edge.
    assign valid_c = ((state_reg == HDR) || (state_reg == BODY)) && grant_has_data && !reset;
    assign xfer    = valid_c && bus.out_ready;

    grant_rotator u_grant_rotator (
        .grant      (grant_reg),
        .advance    (advance),
        .grant_next (grant_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= GRANT_Q1;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        advance     = 1'b0;
        bus.out_sop = 1'b0;
        bus.out_eop = 1'b0;

        case (state_reg)
            IDLE: begin
                // Empty queues are skipped one per cycle.
                if (grant_has_data) begin
                    state_next = HDR;
                end else begin
                    advance = 1'b1;
                end
            end

            HDR: begin
                bus.out_sop = 1'b1;
                bus.out_eop = (hdr_len == '0);
                if (xfer) begin
                    count_next = hdr_len;
                    if (hdr_len == '0) begin
                        advance    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = BODY;
                    end
                end
            end

            BODY: begin
                bus.out_eop = (count_reg == COUNT_WIDTH'(1));
                if (count_reg == '0) begin
                    // Unreachable in normal operation; leave without wrapping.
                    state_next = IDLE;
                end else if (xfer) begin
                    count_next = count_reg - 1'b1;
                    if (count_reg == COUNT_WIDTH'(1)) begin
                        advance    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.out_valid   = valid_c;
    assign bus.out_data    = data_mux;
    assign bus.queue_rd    = grant_reg & {NUM_QUEUES{xfer}};
    assign read_from_queue = grant_reg;
    assign down_counter    = count_reg;

endmodule

// File: doc/output_port_scheduler.md
Name: output_port_scheduler

Overview:
- Per-output-port packet scheduler for the 4x4 switch. It sits directly downstream of the four input queues feeding one output port.
- Grants one queue at a time and forwards a whole packet from it (header byte plus payload bytes). It tracks remaining bytes with a down-counter.
- On end of packet it rotates the grant round-robin 1→2→3→4→1.
- Drives a ready/valid byte stream to the output port.

Parameters:
- DATA_WIDTH, 8: byte width of queue data and output data.
- COUNT_WIDTH, 8: width of the down-counter. Header bits [COUNT_WIDTH-1:0] hold the payload length. COUNT_WIDTH must not exceed DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- queue_empty  in  [1:4]  per-queue empty flag; queues are first-word-fall-through.
- queue_data  in  4*DATA_WIDTH  head word of each queue; queue k occupies slice k-1.
- queue_rd  out  [1:4]  one-hot pop strobe; at most one bit high.
- out_valid  out  1  out_data is valid this cycle.
- out_ready  in  1  downstream accepts the byte this cycle.
- out_data  out  DATA_WIDTH  forwarded byte.
- out_sop  out  1  current byte is the packet header.
- out_eop  out  1  current byte is the last byte of the packet.
- read_from_queue  out  [1:4]  registered one-hot grant; bit 1 = queue 1.
- down_counter  out  COUNT_WIDTH  payload bytes still to send.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE, read_from_queue=4'b1000 (queue 1), down_counter=0.
  - Combinational outputs evaluate to 0: queue_rd, out_valid, out_sop, out_eop.
  - Reset mid-packet abandons the packet; no further pops occur.
- Transfer condition: xfer = out_valid & out_ready.
  - queue_rd = read_from_queue & {4{xfer}}.
  - out_data = queue_data slice selected by the grant.
  - Both are combinational, so pop and acceptance happen in the same cycle.
- States:
  - IDLE:
    - out_valid=0.
    - If the granted queue is non-empty, go to HDR next cycle.
    - Otherwise rotate the grant one step; empty queues are scanned one per cycle.
  - HDR:
    - out_valid = ~queue_empty[grant]; out_sop=1.
    - out_eop = (header[COUNT_WIDTH-1:0]==0).
    - On xfer: down_counter <= header length.
      - Length 0 (header-only packet): rotate grant, go to IDLE.
      - Otherwise go to BODY.
  - BODY:
    - out_valid = ~queue_empty[grant]; out_sop=0.
    - out_eop = (down_counter==1).
    - On xfer: down_counter <= down_counter-1.
    - If down_counter was 1: rotate grant, go to IDLE.
- Rotation updates read_from_queue only at end of packet or on an empty-queue skip in IDLE. The grant is held throughout a packet.
  - An invalid grant (0 or multi-hot) recovers to 4'b1000 on the next rotation.
- Stalls:
  - Queue empty mid-packet: out_valid=0, state and counter held, no pop.
  - out_ready=0: state and counter held, no pop, out_data stable.
- The down-counter never wraps: decrement only from a value ≥1; zero is reached only via end of packet.
- Minimum packet spacing is one IDLE cycle between packets (IDLE→HDR). Back-to-back packets from the same queue are allowed when the rotation returns to it.
- No combinational path from out_ready to out_valid.

Decomposition:
- Shared package switch_pkg holds:
  - NUM_QUEUES=4.
  - the grant reset constant GRANT_Q1=4'b1000.
  - the state encoding (IDLE=2'd0, HDR=2'd1, BODY=2'd2).
  - DATA_WIDTH and COUNT_WIDTH defaults.
- One natural sub-module: grant_rotator.
  - Combinational; input the current one-hot grant and an advance flag, output the next grant.
  - Rotates 1→2→3→4→1; an invalid grant maps to queue 1.

Test Plan:
- Reset with all queues empty → read_from_queue 1000, 0100, 0010, 0001, 1000 on successive cycles; queue_rd=0; out_valid=0.
- Queue 2 only holds header 8'h03 + payload A1 A2 A3, out_ready=1 → four transfers.
  - Bytes 03(sop), A1, A2, A3(eop); queue_rd=0100 on each.
  - down_counter 3,2,1,0; grant ends at 0010.
- All queues hold one 2-byte packet (hdr 8'h01) → packets emitted in order q1,q2,q3,q4.
  - Exactly one IDLE cycle between them; never two queue_rd bits set together.
- Header 8'h00 on queue 1 → one cycle with sop=1 and eop=1; grant becomes 0100; down_counter stays 0.
- Hold out_ready=0 for 5 cycles mid-payload (down_counter=2), then make queue 3 empty for 3 cycles.
  - Across both stalls: no pops, counter held at 2, out_data stable while valid.
  - Packet resumes and completes.
- Assert reset during BODY with down_counter=5 → next cycle state IDLE, grant 1000, counter 0, no queue_rd pulse.
